// File: rtl/audio_i2s_tx_pkg.sv
// Shared I2S frame geometry and slot helpers for the audio transmit path.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package audio_pkg;

    localparam int I2S_SLOT_BITS  = 32;
    localparam int I2S_FRAME_BITS = 64;

    // Slot index within a 64-bit stereo frame.
    typedef logic [$clog2(I2S_FRAME_BITS)-1:0] slot_t;

    // Word select leads the MSB by one BCLK, so the right channel window
    // opens on the last slot of the left word and closes one slot early.
    localparam slot_t LR_HIGH_FIRST = slot_t'(I2S_SLOT_BITS - 1);
    localparam slot_t LR_HIGH_LAST  = slot_t'(I2S_FRAME_BITS - 2);
    localparam slot_t SLOT_IDLE     = slot_t'(I2S_FRAME_BITS - 1);
    localparam slot_t SLOT_LEFT_MSB = slot_t'(0);

    function automatic logic lrclk_for_slot(input slot_t s);
        return (s >= LR_HIGH_FIRST) && (s <= LR_HIGH_LAST);
    endfunction

endpackage

// File: rtl/audio_i2s_tx_if.sv
// Sample input strobe plus the three-wire I2S output bundle.
// Latency: n/a (wires only).
// Backpressure: none; the producer strobes samples, the DAC side is free-running.
interface audio_i2s_tx_if #(
    parameter int DATA_WIDTH = 32
);
    logic signed [DATA_WIDTH-1:0] data_in;
    logic                         data_in_valid;
    logic                         i2s_bclk;
    logic                         i2s_lrclk;
    logic                         i2s_sdata;

    // Producer side: drives samples, observes the serial stream.
    modport master (
        output data_in,
        output data_in_valid,
        input  i2s_bclk,
        input  i2s_lrclk,
        input  i2s_sdata
    );

    // Transmitter side: consumes samples, drives the serial stream.
    modport slave (
        input  data_in,
        input  data_in_valid,
        output i2s_bclk,
        output i2s_lrclk,
        output i2s_sdata
    );
endinterface

// File: rtl/audio_i2s_tx_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with registered occupancy.
// Latency: write visible on rd_data the cycle after; level updates the cycle after.
// Backpressure: writes while full are ignored unless a read happens in the same cycle.
module sync_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 8,
    localparam int AW = $clog2(FIFO_DEPTH),
    localparam int LW = AW + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  full,
    output logic                  empty,
    output logic [LW-1:0]         level
);
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic                  do_wr;
    logic                  do_rd;

    assign full    = (level == LW'(FIFO_DEPTH));
    assign empty   = (level == '0);
    assign do_rd   = rd_en && !empty;
    // A pop frees the head slot in the same cycle, so a full FIFO can still
    // take a write when it is being read.
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = mem[rd_ptr];

    // Storage array; no reset needed since level gates every read.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers and occupancy counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/audio_i2s_tx.sv
// Buffers mono samples and serialises them as identical left/right I2S words.
// Latency: sample-to-MSB up to one full frame (64 BCLKs) plus one cycle.
// Backpressure: none; full FIFO drops the sample (sticky overflow), empty frame sends zeros (sticky underflow).
module audio_i2s_tx
    import audio_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int OUT_WIDTH  = 24,
    parameter int BCLK_DIV   = 8,
    parameter int FIFO_DEPTH = 8,
    localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
    input  logic           clk,
    input  logic           rst,
    audio_i2s_tx_if.slave  bus,
    input  logic           enable,
    input  logic           clear_flags,
    output logic [LW-1:0]  fifo_level,
    output logic           overflow,
    output logic           underflow
);
    localparam int DIVW = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
    localparam logic [DIVW-1:0] DIV_LAST = DIVW'(BCLK_DIV - 1);
    localparam logic [DIVW-1:0] DIV_HALF = DIVW'(BCLK_DIV / 2);
    localparam logic [5:0]      OUT_W6   = 6'(OUT_WIDTH);

    logic [DIVW-1:0]       div_cnt;
    logic [DIVW-1:0]       div_nxt;
    slot_t                 bit_cnt;
    slot_t                 slot_nxt;
    logic [OUT_WIDTH-1:0]  frame_reg;
    logic [OUT_WIDTH-1:0]  load_val;
    logic [OUT_WIDTH-1:0]  frame_src;
    logic [OUT_WIDTH-1:0]  frame_shifted;
    logic                  bclk_q;
    logic                  lrclk_q;
    logic                  sdata_q;
    logic                  tick;
    logic                  load;
    logic                  pop;
    logic                  in_word;
    logic                  sd_nxt;
    logic                  ovf_evt;
    logic                  unf_evt;

    logic [DATA_WIDTH-1:0] fifo_rd_data;
    logic                  fifo_full;
    logic                  fifo_empty;

    sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (bus.data_in_valid),
        .wr_data (bus.data_in),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    // One tick per BCLK period, on the last divider count.
    assign tick     = enable && (div_cnt == DIV_LAST);
    assign div_nxt  = tick ? '0 : div_cnt + DIVW'(1);
    assign slot_nxt = bit_cnt + slot_t'(1);

    // Entering slot 0 starts a new frame: take the FIFO head, or zeros if dry.
    assign load     = tick && (slot_nxt == SLOT_LEFT_MSB);
    assign pop      = load && !fifo_empty;
    assign load_val = fifo_empty ? '0 : fifo_rd_data[DATA_WIDTH-1 -: OUT_WIDTH];

    // The MSB goes out on the load tick itself, so select the incoming word then.
    assign frame_src     = load ? load_val : frame_reg;
    assign frame_shifted = frame_src << slot_nxt[4:0];
    assign in_word       = ({1'b0, slot_nxt[4:0]} < OUT_W6);
    assign sd_nxt        = in_word && frame_shifted[OUT_WIDTH-1];

    // A write on a pop cycle always fits, so only a full FIFO without a pop drops.
    assign ovf_evt = bus.data_in_valid && fifo_full && !pop;
    assign unf_evt = load && fifo_empty;

    // Truncated sample bits and unused shifter bits are intentionally discarded.
    logic unused_bits;
    assign unused_bits = ^{fifo_rd_data, frame_shifted};

    // Divider, slot counter and the registered I2S pins.
    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            div_cnt <= '0;
            bit_cnt <= SLOT_IDLE;
            bclk_q  <= 1'b0;
            lrclk_q <= 1'b0;
            sdata_q <= 1'b0;
        end else begin
            div_cnt <= div_nxt;
            // BCLK mirrors the divider count it is leaving with, so the
            // tick edge is also the BCLK falling edge.
            bclk_q  <= (div_nxt >= DIV_HALF);
            if (tick) begin
                bit_cnt <= slot_nxt;
                lrclk_q <= lrclk_for_slot(slot_nxt);
                sdata_q <= sd_nxt;
            end
        end
    end

    // Frame register holds the word for both channel slots.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_reg <= '0;
        end else if (load) begin
            frame_reg <= load_val;
        end
    end

    // Sticky error flags; a new event in the same cycle beats a clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (ovf_evt) begin
                overflow <= 1'b1;
            end else if (clear_flags) begin
                overflow <= 1'b0;
            end
            if (unf_evt) begin
                underflow <= 1'b1;
            end else if (clear_flags) begin
                underflow <= 1'b0;
            end
        end
    end

    assign bus.i2s_bclk  = bclk_q;
    assign bus.i2s_lrclk = lrclk_q;
    assign bus.i2s_sdata = sdata_q;

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Drives samples into audio_i2s_tx and decodes the I2S stream against a scoreboard.
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_audio_i2s_tx;

    logic       clk;
    logic       rst;
    logic       enable;
    logic       clear_flags;
    logic [3:0] fifo_level;
    logic       overflow;
    logic       underflow;

    audio_i2s_tx_if #(.DATA_WIDTH(32)) bus ();

    audio_i2s_tx #(
        .DATA_WIDTH (32),
        .OUT_WIDTH  (24),
        .BCLK_DIV   (8),
        .FIFO_DEPTH (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .enable      (enable),
        .clear_flags (clear_flags),
        .fifo_level  (fifo_level),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] din;
        logic [23:0] word;
        logic [3:0]  lvl;
    } vec_t;
    vec_t tbl[8];

    logic [23:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_sample(input logic [31:0] d);
        bus.data_in       = d;
        bus.data_in_valid = 1'b1;
        step();
        bus.data_in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        exp_q.delete();
    endtask

    // Serial decoder: samples on BCLK rising edges, frames words on LRCLK changes.
    logic        prev_bclk;
    logic        last_lr;
    int          bitpos;
    logic [31:0] slot_word;
    logic [23:0] left_exp;

    always @(negedge clk) begin
        if (rst || !enable) begin
            prev_bclk = bus.i2s_bclk;
            last_lr   = 1'b0;
            bitpos    = -2;
            slot_word = '0;
        end else begin
            if (bus.i2s_bclk && !prev_bclk) begin
                if (bus.i2s_lrclk != last_lr) begin
                    if (bitpos == 30) begin
                        slot_word = {slot_word[30:0], bus.i2s_sdata};
                        if (!last_lr) begin
                            if (exp_q.size() > 0) left_exp = exp_q.pop_front();
                            else                  left_exp = 24'h0;
                            check("left_word", slot_word, {left_exp, 8'h00});
                        end else begin
                            check("right_word", slot_word, {left_exp, 8'h00});
                        end
                    end
                    last_lr   = bus.i2s_lrclk;
                    bitpos    = -1;
                    slot_word = '0;
                end else begin
                    bitpos++;
                    if (bitpos >= 0 && bitpos <= 30) slot_word = {slot_word[30:0], bus.i2s_sdata};
                end
            end
            prev_bclk = bus.i2s_bclk;
        end
    end

    initial begin
        int bclk_err;
        int lr_err;
        int s;

        tbl[0] = '{32'h7FFFFF00, 24'h7FFFFF, 4'd1};
        tbl[1] = '{32'h80000100, 24'h800001, 4'd2};
        tbl[2] = '{32'h12345678, 24'h123456, 4'd3};
        tbl[3] = '{32'hFFFFFFFF, 24'hFFFFFF, 4'd4};
        tbl[4] = '{32'h000000FF, 24'h000000, 4'd5};
        tbl[5] = '{32'hA5A5A5A5, 24'hA5A5A5, 4'd6};
        tbl[6] = '{32'h00000100, 24'h000001, 4'd7};
        tbl[7] = '{32'hDEADBEEF, 24'hDEADBE, 4'd8};

        rst               = 1'b0;
        enable            = 1'b0;
        clear_flags       = 1'b0;
        bus.data_in       = '0;
        bus.data_in_valid = 1'b0;
        do_reset();

        // Reset state.
        check("rst_bclk",      32'(bus.i2s_bclk),  32'd0);
        check("rst_lrclk",     32'(bus.i2s_lrclk), 32'd0);
        check("rst_sdata",     32'(bus.i2s_sdata), 32'd0);
        check("rst_level",     32'(fifo_level),    32'd0);
        check("rst_overflow",  32'(overflow),      32'd0);
        check("rst_underflow", 32'(underflow),     32'd0);
        check("rst_bit_cnt",   32'(dut.bit_cnt),   32'd63);

        // Clock pattern from reset with an empty FIFO, plus underflow/clear timing.
        enable   = 1'b1;
        bclk_err = 0;
        lr_err   = 0;
        for (int k = 1; k <= 1100; k++) begin
            step();
            s = (63 + k / 8) % 64;
            if (bus.i2s_bclk !== ((k % 8) >= 4)) bclk_err++;
            if (bus.i2s_lrclk !== (s >= 31 && s <= 62)) lr_err++;
            if (k == 7)   check("unf_before_first_tick", 32'(underflow), 32'd0);
            if (k == 8)   check("unf_first_tick",        32'(underflow), 32'd1);
            if (k == 20)  clear_flags = 1'b1;
            if (k == 21) begin
                check("unf_cleared", 32'(underflow), 32'd0);
                clear_flags = 1'b0;
            end
            if (k == 519) check("unf_rearmed",     32'(underflow), 32'd0);
            if (k == 520) check("unf_next_frame",  32'(underflow), 32'd1);
        end
        check("bclk_pattern",  32'(bclk_err), 32'd0);
        check("lrclk_pattern", 32'(lr_err),   32'd0);

        // Mid-frame disable drops the counters back at once.
        enable = 1'b0;
        step();
        check("dis_bclk",    32'(bus.i2s_bclk),  32'd0);
        check("dis_lrclk",   32'(bus.i2s_lrclk), 32'd0);
        check("dis_sdata",   32'(bus.i2s_sdata), 32'd0);
        check("dis_bit_cnt", 32'(dut.bit_cnt),   32'd63);
        check("dis_div_cnt", 32'(dut.div_cnt),   32'd0);

        // Fill while idle, overflow on the ninth, set-wins on clear, then drain.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            write_sample(tbl[i].din);
            exp_q.push_back(tbl[i].word);
            check("fill_level", 32'(fifo_level), 32'(tbl[i].lvl));
        end
        write_sample(32'h11111111);
        check("ovf_level", 32'(fifo_level), 32'd8);
        check("ovf_set",   32'(overflow),   32'd1);
        clear_flags = 1'b1;
        write_sample(32'h22222222);
        clear_flags = 1'b0;
        check("ovf_set_wins", 32'(overflow), 32'd1);
        clear_flags = 1'b1;
        step();
        clear_flags = 1'b0;
        check("ovf_cleared", 32'(overflow), 32'd0);
        check("idle_sdata",  32'(bus.i2s_sdata), 32'd0);
        enable = 1'b1;
        repeat (9 * 512 + 100) step();
        check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
        check("drain_level",       32'(fifo_level),   32'd0);
        check("drain_underflow",   32'(underflow),    32'd1);
        enable = 1'b0;
        step();

        // Full FIFO with a write on the pop tick.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            write_sample(tbl[7 - i].din);
            exp_q.push_back(tbl[7 - i].word);
        end
        enable = 1'b1;
        repeat (7) step();
        check("pre_pop_level", 32'(fifo_level), 32'd8);
        write_sample(32'h13579BDF);
        exp_q.push_back(24'h13579B);
        check("pop_wr_level",    32'(fifo_level), 32'd8);
        check("pop_wr_overflow", 32'(overflow),   32'd0);
        step();
        check("post_pop_level", 32'(fifo_level), 32'd8);
        repeat (9 * 512 + 100) step();
        check("popwr_queue_empty", 32'(exp_q.size()), 32'd0);
        check("popwr_overflow",    32'(overflow),     32'd0);
        enable = 1'b0;
        step();

        // Reset in the right-channel slot with samples queued.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            write_sample(tbl[i].din);
            exp_q.push_back(tbl[i].word);
        end
        enable = 1'b1;
        repeat (328) step();
        check("pre_rst_slot",  32'(dut.bit_cnt),  32'd40);
        check("pre_rst_level", 32'(fifo_level),   32'd2);
        rst = 1'b1;
        step();
        exp_q.delete();
        check("midrst_bclk",    32'(bus.i2s_bclk),  32'd0);
        check("midrst_lrclk",   32'(bus.i2s_lrclk), 32'd0);
        check("midrst_sdata",   32'(bus.i2s_sdata), 32'd0);
        check("midrst_level",   32'(fifo_level),    32'd0);
        check("midrst_bit_cnt", 32'(dut.bit_cnt),   32'd63);
        check("midrst_unf",     32'(underflow),     32'd0);
        rst = 1'b0;
        repeat (600) step();
        check("post_rst_discarded", 32'(underflow), 32'd1);
        enable = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
